// File: rtl/chasy_pkg.sv
// Shared types and constants for the chasy time-setting controller:
// session states, field limits, field-select codes and time-word packing.
package chasy_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        EDIT_HOUR = 3'd1,
        EDIT_MIN  = 3'd2,
        EDIT_SEC  = 3'd3,
        COMMIT    = 3'd4
    } setup_state_t;

    localparam logic [7:0] HOUR_MAX   = 8'd23;
    localparam logic [7:0] MINSEC_MAX = 8'd59;

    localparam logic [1:0] FIELD_NONE = 2'd0;
    localparam logic [1:0] FIELD_HOUR = 2'd1;
    localparam logic [1:0] FIELD_MIN  = 2'd2;
    localparam logic [1:0] FIELD_SEC  = 2'd3;

    localparam int HOUR_LSB = 16;
    localparam int MIN_LSB  = 8;
    localparam int SEC_LSB  = 0;

    // Out-of-range captures from the running clock start editing at zero.
    function automatic logic [7:0] clamp_field(input logic [7:0] val, input logic [7:0] max_val);
        return (val > max_val) ? 8'd0 : val;
    endfunction

    // One step up or down with wrap at 0 and max_val.
    function automatic logic [7:0] step_field(input logic [7:0] val, input logic [7:0] max_val,
                                              input logic up);
        if (up) begin
            return (val >= max_val) ? 8'd0 : val + 8'd1;
        end
        return (val == 8'd0 || val > max_val) ? max_val : val - 8'd1;
    endfunction

endpackage

// File: rtl/chasy_btn_repeat.sv
// Edge detect plus hold-to-repeat for one debounced button; emits a one-cycle
// step on the rising edge, after REPEAT_DELAY held clocks, then every REPEAT_RATE.
module chasy_btn_repeat #(
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000,
    parameter int CNT_W        = 25
) (
    input  logic clock,
    input  logic reset,
    input  logic level,
    input  logic clear,
    output logic rise,
    output logic step
);

    logic             prev;
    logic             repeating;
    logic             rep_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    assign rise = level & ~prev;

    // cnt holds the number of clocks since the last step while the button is held.
    always_comb begin
        step     = 1'b0;
        cnt_next = cnt;
        rep_next = repeating;
        if (!level || clear) begin
            cnt_next = '0;
            rep_next = 1'b0;
        end else if (!prev) begin
            step     = 1'b1;
            cnt_next = CNT_W'(1);
            rep_next = 1'b0;
        end else if (!repeating && cnt == CNT_W'(REPEAT_DELAY)) begin
            step     = 1'b1;
            cnt_next = CNT_W'(1);
            rep_next = 1'b1;
        end else if (repeating && cnt == CNT_W'(REPEAT_RATE)) begin
            step     = 1'b1;
            cnt_next = CNT_W'(1);
        end else begin
            cnt_next = cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev      <= 1'b0;
            cnt       <= '0;
            repeating <= 1'b0;
        end else begin
            prev      <= level;
            cnt       <= cnt_next;
            repeating <= rep_next;
        end
    end

endmodule

// File: rtl/chasy_setup.sv
// Front-panel time-setting controller: mode walks hour/min/sec editing and
// commits the edited word to the clock core with a single setup_imp pulse.
module chasy_setup
    import chasy_pkg::*;
#(
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000,
    parameter int TIMEOUT      = 500000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        btn_mode,
    input  logic        btn_inc,
    input  logic        btn_dec,
    input  logic [23:0] cur_time,
    output logic [23:0] setup_data,
    output logic        setup_imp,
    output logic        edit_active,
    output logic [1:0]  edit_field,
    output logic [2:0]  dbg_state
);

    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam int TO_W    = $clog2(TIMEOUT + 1);

    setup_state_t state, state_next;
    logic [7:0]   hour_q, min_q, sec_q;
    logic [7:0]   hour_next, min_next, sec_next;
    logic [TO_W-1:0] to_cnt, to_next;
    logic         mode_prev, mode_rise;
    logic         inc_rise, inc_step, dec_rise, dec_step;
    logic         any_rise, is_edit, timed_out, do_step, step_up;

    chasy_btn_repeat #(
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE),
        .CNT_W       (REP_W)
    ) u_inc (
        .clock(clock),
        .reset(reset),
        .level(btn_inc),
        .clear(btn_dec),
        .rise (inc_rise),
        .step (inc_step)
    );

    chasy_btn_repeat #(
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE),
        .CNT_W       (REP_W)
    ) u_dec (
        .clock(clock),
        .reset(reset),
        .level(btn_dec),
        .clear(btn_inc),
        .rise (dec_rise),
        .step (dec_step)
    );

    assign mode_rise = btn_mode & ~mode_prev;
    assign any_rise  = mode_rise | inc_rise | dec_rise;
    assign is_edit   = (state == EDIT_HOUR) || (state == EDIT_MIN) || (state == EDIT_SEC);
    assign timed_out = is_edit && !any_rise && (to_cnt == TO_W'(TIMEOUT - 1));
    assign do_step   = inc_step ^ dec_step;
    assign step_up   = inc_step;

    assign setup_data  = {hour_q, min_q, sec_q};
    assign setup_imp   = (state == COMMIT);
    assign edit_active = is_edit;
    assign dbg_state   = state;

    always_comb begin
        edit_field = FIELD_NONE;
        case (state)
            EDIT_HOUR: edit_field = FIELD_HOUR;
            EDIT_MIN:  edit_field = FIELD_MIN;
            EDIT_SEC:  edit_field = FIELD_SEC;
            default:   edit_field = FIELD_NONE;
        endcase
    end

    // Mode outranks timeout and steps; a step is only applied when mode is quiet.
    always_comb begin
        state_next = state;
        hour_next  = hour_q;
        min_next   = min_q;
        sec_next   = sec_q;
        case (state)
            IDLE: begin
                if (mode_rise) begin
                    hour_next  = clamp_field(cur_time[HOUR_LSB +: 8], HOUR_MAX);
                    min_next   = clamp_field(cur_time[MIN_LSB +: 8], MINSEC_MAX);
                    sec_next   = clamp_field(cur_time[SEC_LSB +: 8], MINSEC_MAX);
                    state_next = EDIT_HOUR;
                end
            end
            EDIT_HOUR: begin
                if (mode_rise)      state_next = EDIT_MIN;
                else if (timed_out) state_next = IDLE;
                else if (do_step)   hour_next = step_field(hour_q, HOUR_MAX, step_up);
            end
            EDIT_MIN: begin
                if (mode_rise)      state_next = EDIT_SEC;
                else if (timed_out) state_next = IDLE;
                else if (do_step)   min_next = step_field(min_q, MINSEC_MAX, step_up);
            end
            EDIT_SEC: begin
                if (mode_rise)      state_next = COMMIT;
                else if (timed_out) state_next = IDLE;
                else if (do_step)   sec_next = step_field(sec_q, MINSEC_MAX, step_up);
            end
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        to_next = to_cnt + TO_W'(1);
        if (!is_edit || any_rise) begin
            to_next = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            hour_q    <= 8'd0;
            min_q     <= 8'd0;
            sec_q     <= 8'd0;
            to_cnt    <= '0;
            mode_prev <= 1'b0;
        end else begin
            state     <= state_next;
            hour_q    <= hour_next;
            min_q     <= min_next;
            sec_q     <= sec_next;
            to_cnt    <= to_next;
            mode_prev <= btn_mode;
        end
    end

endmodule

// File: tb/tb_chasy_setup.sv
// Directed bench for chasy_setup with short repeat/timeout parameters.
module tb_chasy_setup;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        btn_mode = 1'b0;
    logic        btn_inc = 1'b0;
    logic        btn_dec = 1'b0;
    logic [23:0] cur_time = 24'd0;
    logic [23:0] setup_data;
    logic        setup_imp;
    logic        edit_active;
    logic [1:0]  edit_field;
    logic [2:0]  dbg_state;

    int n_cmp = 0;
    int n_bad = 0;
    int imp_count = 0;

    chasy_setup #(
        .REPEAT_DELAY(10),
        .REPEAT_RATE (4),
        .TIMEOUT     (50)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .btn_dec    (btn_dec),
        .cur_time   (cur_time),
        .setup_data (setup_data),
        .setup_imp  (setup_imp),
        .edit_active(edit_active),
        .edit_field (edit_field),
        .dbg_state  (dbg_state)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (setup_imp === 1'b1) imp_count++;
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic press_mode();
        btn_mode = 1'b1; tick();
        btn_mode = 1'b0; tick();
    endtask

    task automatic press_inc();
        btn_inc = 1'b1; tick();
        btn_inc = 1'b0; tick();
    endtask

    task automatic press_dec();
        btn_dec = 1'b1; tick();
        btn_dec = 1'b0; tick();
    endtask

    task automatic test_reset();
        tick(2);
        n_cmp++;
        if ({setup_data, setup_imp, edit_active, edit_field} !== 28'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 0", {setup_data, setup_imp, edit_active, edit_field});
        end
        n_cmp++;
        if (dbg_state !== 3'd0) begin
            n_bad++; $display("FAIL reset_state: got %0d want 0", dbg_state);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_full_session();
        cur_time = {8'd12, 8'd34, 8'd56};
        press_mode();
        n_cmp++;
        if ({edit_active, edit_field, setup_data} !== {1'b1, 2'd1, 24'h0C2238}) begin
            n_bad++; $display("FAIL load_hour: got %b %0d %h want 1 1 0c2238", edit_active, edit_field, setup_data);
        end
        press_mode();
        n_cmp++;
        if (edit_field !== 2'd2) begin
            n_bad++; $display("FAIL field_min: got %0d want 2", edit_field);
        end
        press_mode();
        n_cmp++;
        if (edit_field !== 2'd3) begin
            n_bad++; $display("FAIL field_sec: got %0d want 3", edit_field);
        end
        btn_mode = 1'b1; tick();
        n_cmp++;
        if ({setup_imp, edit_active, setup_data} !== {1'b1, 1'b0, 24'h0C2238}) begin
            n_bad++; $display("FAIL commit: got imp=%b act=%b data=%h want 1 0 0c2238", setup_imp, edit_active, setup_data);
        end
        btn_mode = 1'b0; tick();
        n_cmp++;
        if ({setup_imp, edit_active, edit_field, dbg_state} !== 7'd0) begin
            n_bad++; $display("FAIL post_commit_idle: got imp=%b act=%b fld=%0d st=%0d want 0", setup_imp, edit_active, edit_field, dbg_state);
        end
        tick(2);
        n_cmp++;
        if (imp_count !== 1) begin
            n_bad++; $display("FAIL imp_once: got %0d want 1", imp_count);
        end
    endtask

    task automatic test_wrap();
        cur_time = {8'd23, 8'd0, 8'd0};
        press_mode();
        press_inc();
        n_cmp++;
        if (setup_data !== 24'h000000 || edit_field !== 2'd1) begin
            n_bad++; $display("FAIL hour_wrap_up: got %h fld %0d want 000000 fld 1", setup_data, edit_field);
        end
        press_mode();
        press_dec();
        n_cmp++;
        if (setup_data !== 24'h003B00) begin
            n_bad++; $display("FAIL min_wrap_down: got %h want 003b00", setup_data);
        end
        press_mode();
        press_dec();
        n_cmp++;
        if (setup_data !== 24'h003B3B) begin
            n_bad++; $display("FAIL sec_wrap_down: got %h want 003b3b", setup_data);
        end
        press_mode();
        tick();
        n_cmp++;
        if (imp_count !== 2 || setup_data !== 24'h003B3B) begin
            n_bad++; $display("FAIL wrap_commit: got imp=%0d data=%h want 2 003b3b", imp_count, setup_data);
        end
    endtask

    task automatic test_clamp();
        cur_time = {8'd30, 8'd60, 8'd61};
        press_mode();
        n_cmp++;
        if (setup_data !== 24'h000000) begin
            n_bad++; $display("FAIL clamp_load: got %h want 000000", setup_data);
        end
        cur_time = {8'd7, 8'd7, 8'd7};
        press_inc();
        n_cmp++;
        if (setup_data !== 24'h010000) begin
            n_bad++; $display("FAIL cur_time_ignored: got %h want 010000", setup_data);
        end
        press_mode();
        press_mode();
        press_mode();
        tick();
        n_cmp++;
        if (imp_count !== 3) begin
            n_bad++; $display("FAIL clamp_commit: got %0d want 3", imp_count);
        end
    endtask

    task automatic test_repeat();
        cur_time = 24'd0;
        press_mode();
        press_mode();
        press_mode();
        btn_inc = 1'b1;
        tick(10);
        n_cmp++;
        if (setup_data[7:0] !== 8'd1) begin
            n_bad++; $display("FAIL repeat_before_delay: got %0d want 1", setup_data[7:0]);
        end
        tick();
        n_cmp++;
        if (setup_data[7:0] !== 8'd2) begin
            n_bad++; $display("FAIL repeat_first: got %0d want 2", setup_data[7:0]);
        end
        tick(11);
        btn_inc = 1'b0;
        tick(3);
        n_cmp++;
        if (setup_data !== 24'h000004) begin
            n_bad++; $display("FAIL repeat_total: got %h want 000004", setup_data);
        end
    endtask

    task automatic test_simultaneous();
        btn_inc = 1'b1; btn_dec = 1'b1; tick();
        btn_inc = 1'b0; btn_dec = 1'b0; tick();
        n_cmp++;
        if (setup_data !== 24'h000004 || edit_field !== 2'd3) begin
            n_bad++; $display("FAIL inc_dec_together: got %h fld %0d want 000004 fld 3", setup_data, edit_field);
        end
        press_mode();
        tick();
        n_cmp++;
        if (imp_count !== 4) begin
            n_bad++; $display("FAIL repeat_commit: got %0d want 4", imp_count);
        end
        cur_time = {8'd5, 8'd6, 8'd7};
        press_mode();
        btn_mode = 1'b1; btn_inc = 1'b1; tick();
        n_cmp++;
        if (edit_field !== 2'd2 || setup_data !== 24'h050607) begin
            n_bad++; $display("FAIL mode_beats_inc: got fld %0d data %h want 2 050607", edit_field, setup_data);
        end
    endtask

    task automatic test_timeout();
        // EDIT_MIN was entered by the edge just taken; 50 clocks idle ends the session.
        btn_mode = 1'b0; btn_inc = 1'b0; tick();
        tick(48);
        n_cmp++;
        if (edit_active !== 1'b1 || edit_field !== 2'd2) begin
            n_bad++; $display("FAIL timeout_early: got act=%b fld=%0d want 1 2", edit_active, edit_field);
        end
        tick();
        n_cmp++;
        if (edit_active !== 1'b0 || edit_field !== 2'd0 || dbg_state !== 3'd0) begin
            n_bad++; $display("FAIL timeout_idle: got act=%b fld=%0d st=%0d want 0 0 0", edit_active, edit_field, dbg_state);
        end
        n_cmp++;
        if (imp_count !== 4 || setup_data !== 24'h050607) begin
            n_bad++; $display("FAIL timeout_no_commit: got imp=%0d data=%h want 4 050607", imp_count, setup_data);
        end
    endtask

    task automatic test_reset_mid_session();
        cur_time = {8'd1, 8'd2, 8'd3};
        press_mode();
        press_mode();
        press_mode();
        press_inc();
        n_cmp++;
        if (setup_data !== 24'h010204 || edit_field !== 2'd3) begin
            n_bad++; $display("FAIL pre_reset_edit: got %h fld %0d want 010204 3", setup_data, edit_field);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({setup_data, setup_imp, edit_active, edit_field} !== 28'd0) begin
            n_bad++; $display("FAIL async_reset: got %h want 0", {setup_data, setup_imp, edit_active, edit_field});
        end
        tick();
        reset = 1'b1;
        tick(5);
        n_cmp++;
        if (imp_count !== 4 || dbg_state !== 3'd0 || setup_data !== 24'd0) begin
            n_bad++; $display("FAIL post_reset_quiet: got imp=%0d st=%0d data=%h want 4 0 0", imp_count, dbg_state, setup_data);
        end
    endtask

    initial begin
        test_reset();
        test_full_session();
        test_wrap();
        test_clamp();
        test_repeat();
        test_simultaneous();
        test_timeout();
        test_reset_mid_session();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
